// File: rtl/chacha_lane_adder_pkg.sv
// Shared constants and elaboration helpers for the carry-pipelined ChaCha lane adder.
// The rotate helpers are only consumed when CHACHA_ADDER_ROTATE_EN is defined.
package chacha_adder_pkg;

  localparam int ROT_16 = 16;
  localparam int ROT_12 = 12;
  localparam int ROT_8  = 8;
  localparam int ROT_7  = 7;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int ROT_W = $clog2(DEFAULT_DATA_WIDTH);

  function automatic int seg_width(input int data_width, input int segments);
    return data_width / segments;
  endfunction

  function automatic int rot_width(input int data_width);
    return $clog2(data_width);
  endfunction

  // Segments must tile the word exactly, otherwise the top carry bits would be dropped.
  function automatic bit seg_cfg_ok(input int data_width, input int segments);
    return (segments >= 1) && (segments <= data_width) && ((data_width % segments) == 0);
  endfunction

endpackage

// File: rtl/chacha_lane_adder_if.sv
// Valid/ready stream bundle for chacha_lane_adder: operand beat in, sum/carry beat out.
// The rotate amount field exists only when CHACHA_ADDER_ROTATE_EN is defined.
interface chacha_lane_adder_if
  import chacha_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4
);

  logic                          i_s_valid;
  logic                          o_s_ready;
  logic [LANES*DATA_WIDTH-1:0]   i_s_a;
  logic [LANES*DATA_WIDTH-1:0]   i_s_b;
  logic [LANES-1:0]              i_s_lane_en;
`ifdef CHACHA_ADDER_ROTATE_EN
  logic [rot_width(DATA_WIDTH)-1:0] i_s_rot;
`endif
  logic                          o_m_valid;
  logic                          i_m_ready;
  logic [LANES*DATA_WIDTH-1:0]   o_m_sum;
  logic [LANES-1:0]              o_m_carry;

  // slave: the adder's view; master: the producer/consumer around it.
  modport slave (
    input  i_s_valid,
    output o_s_ready,
    input  i_s_a,
    input  i_s_b,
    input  i_s_lane_en,
`ifdef CHACHA_ADDER_ROTATE_EN
    input  i_s_rot,
`endif
    output o_m_valid,
    input  i_m_ready,
    output o_m_sum,
    output o_m_carry
  );

  modport master (
    output i_s_valid,
    input  o_s_ready,
    output i_s_a,
    output i_s_b,
    output i_s_lane_en,
`ifdef CHACHA_ADDER_ROTATE_EN
    output i_s_rot,
`endif
    input  o_m_valid,
    output i_m_ready,
    input  o_m_sum,
    input  o_m_carry
  );

endinterface

// File: rtl/chacha_lane_adder_segment.sv
// One carry-pipeline stage for all lanes: adds segment SEG_IDX of each lane and registers the word.
// With CHACHA_ADDER_ROTATE_EN the last stage also rotates enabled lanes before its register.
module chacha_adder_segment
  import chacha_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int SEGMENTS   = 2,
  parameter int SEG_IDX    = 0
)
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        move_i,
  input  logic                        valid_i,
  input  logic [LANES*DATA_WIDTH-1:0] word_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_i,
  input  logic [LANES-1:0]            carry_i,
`ifdef CHACHA_ADDER_ROTATE_EN
  input  logic [LANES-1:0]            en_i,
  input  logic [rot_width(DATA_WIDTH)-1:0] rot_i,
  output logic [LANES-1:0]            en_o,
  output logic [rot_width(DATA_WIDTH)-1:0] rot_o,
`endif
  output logic                        valid_o,
  output logic [LANES*DATA_WIDTH-1:0] word_o,
  output logic [LANES*DATA_WIDTH-1:0] b_o,
  output logic [LANES-1:0]            carry_o
);

  localparam int SEG_W = seg_width(DATA_WIDTH, SEGMENTS);
  localparam int LO    = SEG_IDX * SEG_W;
`ifdef CHACHA_ADDER_ROTATE_EN
  localparam bit LAST  = (SEG_IDX == SEGMENTS - 1);
  localparam int RW    = rot_width(DATA_WIDTH);
`endif

  logic [LANES*DATA_WIDTH-1:0] word_d, word_q, b_q;
  logic [LANES-1:0]            carry_d, carry_q;
  logic                        valid_q;
`ifdef CHACHA_ADDER_ROTATE_EN
  logic [LANES-1:0]            en_q;
  logic [RW-1:0]               rot_q;
`endif

  // Word holds finished low segments and untouched high A bits; only this slice changes here.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [SEG_W:0]          slice_sum;
    logic [DATA_WIDTH-1:0]   lane_word;

    assign slice_sum = {1'b0, word_i[l*DATA_WIDTH+LO +: SEG_W]}
                     + {1'b0, b_i[l*DATA_WIDTH+LO +: SEG_W]}
                     + {{SEG_W{1'b0}}, carry_i[l]};

    always_comb begin
      lane_word = word_i[l*DATA_WIDTH +: DATA_WIDTH];
      lane_word[LO +: SEG_W] = slice_sum[SEG_W-1:0];
    end

    assign carry_d[l] = slice_sum[SEG_W];

`ifdef CHACHA_ADDER_ROTATE_EN
    if (LAST) begin : g_rot
      logic [DATA_WIDTH-1:0] rotated;
      assign rotated = (lane_word << rot_i) | (lane_word >> (DATA_WIDTH - int'(rot_i)));
      assign word_d[l*DATA_WIDTH +: DATA_WIDTH] = en_i[l] ? rotated : lane_word;
    end else begin : g_pass
      assign word_d[l*DATA_WIDTH +: DATA_WIDTH] = lane_word;
    end
`else
    assign word_d[l*DATA_WIDTH +: DATA_WIDTH] = lane_word;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      b_q     <= '0;
      carry_q <= '0;
`ifdef CHACHA_ADDER_ROTATE_EN
      en_q    <= '0;
      rot_q   <= '0;
`endif
    end else if (move_i) begin
      valid_q <= valid_i;
      word_q  <= word_d;
      b_q     <= b_i;
      carry_q <= carry_d;
`ifdef CHACHA_ADDER_ROTATE_EN
      en_q    <= en_i;
      rot_q   <= rot_i;
`endif
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;
  assign b_o     = b_q;
  assign carry_o = carry_q;
`ifdef CHACHA_ADDER_ROTATE_EN
  assign en_o    = en_q;
  assign rot_o   = rot_q;
`endif

endmodule

// File: rtl/chacha_lane_adder.sv
// Multi-lane modular adder with a SEGMENTS-deep registered carry chain and valid/ready flow control.
// Optional per-beat left rotate of the result is enabled by defining CHACHA_ADDER_ROTATE_EN.
module chacha_lane_adder
  import chacha_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int SEGMENTS   = 2
)
(
  input  logic                 i_aclk,
  input  logic                 i_areset,
  chacha_lane_adder_if.slave   stream
);

  localparam int W = LANES * DATA_WIDTH;
`ifdef CHACHA_ADDER_ROTATE_EN
  localparam int RW = rot_width(DATA_WIDTH);
`endif

  if (!seg_cfg_ok(DATA_WIDTH, SEGMENTS)) begin : g_cfg_err
    $error("chacha_lane_adder: DATA_WIDTH must be a multiple of SEGMENTS, 1 <= SEGMENTS <= DATA_WIDTH");
  end

  logic [W-1:0]       word_c  [SEGMENTS+1];
  logic [W-1:0]       b_c     [SEGMENTS+1];
  logic [LANES-1:0]   carry_c [SEGMENTS+1];
  logic [SEGMENTS:0]  valid_c;
  logic [SEGMENTS-1:0] move;
  logic [W-1:0]       b_in;
  logic               unused_tail;
`ifdef CHACHA_ADDER_ROTATE_EN
  logic [LANES-1:0]   en_c    [SEGMENTS+1];
  logic [RW-1:0]      rot_c   [SEGMENTS+1];
`endif

  // Disabled lanes add zero, which also guarantees their carry-out stays 0.
  for (genvar l = 0; l < LANES; l++) begin : g_mask
    assign b_in[l*DATA_WIDTH +: DATA_WIDTH] =
      stream.i_s_lane_en[l] ? stream.i_s_b[l*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign word_c[0]  = stream.i_s_a;
  assign b_c[0]     = b_in;
  assign carry_c[0] = '0;
  assign valid_c[0] = stream.i_s_valid;
`ifdef CHACHA_ADDER_ROTATE_EN
  assign en_c[0]    = stream.i_s_lane_en;
  assign rot_c[0]   = stream.i_s_rot;
`endif

  // A stage may load when it is empty or everything downstream of it is moving.
  always_comb begin
    move = '0;
    move[SEGMENTS-1] = ~valid_c[SEGMENTS] | stream.i_m_ready;
    for (int k = SEGMENTS - 2; k >= 0; k--) begin
      move[k] = ~valid_c[k+1] | move[k+1];
    end
  end

  for (genvar k = 0; k < SEGMENTS; k++) begin : g_seg
    chacha_adder_segment #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .SEGMENTS   (SEGMENTS),
      .SEG_IDX    (k)
    ) u_seg (
      .clk_i   (i_aclk),
      .rst_i   (i_areset),
      .move_i  (move[k]),
      .valid_i (valid_c[k]),
      .word_i  (word_c[k]),
      .b_i     (b_c[k]),
      .carry_i (carry_c[k]),
`ifdef CHACHA_ADDER_ROTATE_EN
      .en_i    (en_c[k]),
      .rot_i   (rot_c[k]),
      .en_o    (en_c[k+1]),
      .rot_o   (rot_c[k+1]),
`endif
      .valid_o (valid_c[k+1]),
      .word_o  (word_c[k+1]),
      .b_o     (b_c[k+1]),
      .carry_o (carry_c[k+1])
    );
  end

  assign stream.o_s_ready = move[0] & ~i_areset;
  assign stream.o_m_valid = valid_c[SEGMENTS];
  assign stream.o_m_sum   = word_c[SEGMENTS];
  assign stream.o_m_carry = carry_c[SEGMENTS];

`ifdef CHACHA_ADDER_ROTATE_EN
  assign unused_tail = ^b_c[SEGMENTS] ^ ^en_c[SEGMENTS] ^ ^rot_c[SEGMENTS];
`else
  assign unused_tail = ^b_c[SEGMENTS];
`endif

endmodule

// File: tb/tb_chacha_lane_adder.sv
// Directed bench for chacha_lane_adder: vector table, stall/toggle streams, mid-stream reset.
// Rotate vectors are added when CHACHA_ADDER_ROTATE_EN is defined.
module tb_chacha_lane_adder;
  import chacha_adder_pkg::*;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int SG = 2;
  localparam int W  = DW * LN;

  typedef struct {
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [LN-1:0]    en;
    logic [ROT_W-1:0] rot;
    logic [W-1:0]     sum;
    logic [LN-1:0]    carry;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  chacha_lane_adder_if #(.DATA_WIDTH(DW), .LANES(LN)) bus();

  chacha_lane_adder #(.DATA_WIDTH(DW), .LANES(LN), .SEGMENTS(SG)) dut (
    .i_aclk   (clk),
    .i_areset (rst),
    .stream   (bus)
  );

  task automatic check_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_beat(input logic vld, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [LN-1:0] en, input logic [ROT_W-1:0] rot);
    bus.i_s_valid   = vld;
    bus.i_s_a       = a;
    bus.i_s_b       = b;
    bus.i_s_lane_en = en;
`ifdef CHACHA_ADDER_ROTATE_EN
    bus.i_s_rot     = rot;
`else
    if (rot != '0) $display("note: rotate amount ignored in this build");
`endif
  endtask

  // Single beat into an empty pipeline; called just after a rising edge.
  task automatic apply_vec(input vec_t v, input string name);
    int lat;
    bus.i_m_ready = 1'b1;
    drive_beat(1'b1, v.a, v.b, v.en, v.rot);
    #1;
    check_i({name, " s_ready"}, int'(bus.o_s_ready), 1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      bus.i_s_valid = 1'b0;
      lat++;
    end while (!bus.o_m_valid && lat < 10);
    check_i({name, " latency"}, lat, SG);
    check_v({name, " sum"}, bus.o_m_sum, v.sum);
    check_v({name, " carry"}, W'(bus.o_m_carry), W'(v.carry));
    @(posedge clk); #1;
    check_i({name, " drained"}, int'(bus.o_m_valid), 0);
  endtask

  // Continuous input of nb beats (A=n, B=0x10*n, sum=0x11*n) against a stall window or toggling ready.
  task automatic run_stream(input int nb, input bit toggle, input string name);
    int sent, rcv, c, extra;
    bit saw_full, saw_pushpop, push, pop;
    sent = 0; rcv = 0; c = 0;
    saw_full = 0; saw_pushpop = 0;
    while (rcv < nb && c < 100) begin
      bus.i_m_ready = toggle ? (c % 2 == 1) : !(c >= 3 && c <= 7);
      drive_beat(sent < nb, {LN{32'(sent + 1)}}, {LN{32'((sent + 1) * 16)}}, '1, '0);
      #4;
      if (bus.o_m_valid) begin
        check_v({name, " sum"}, bus.o_m_sum, {LN{32'((rcv + 1) * 17)}});
        check_v({name, " carry"}, W'(bus.o_m_carry), '0);
      end
      if (!bus.o_s_ready) begin
        saw_full = 1;
        check_i({name, " held beats"}, sent - rcv, SG);
      end
      if (bus.i_m_ready) check_i({name, " ready with pop"}, int'(bus.o_s_ready), 1);
      push = bus.i_s_valid && bus.o_s_ready;
      pop  = bus.o_m_valid && bus.i_m_ready;
      if (push && pop && (sent - rcv) == SG) saw_pushpop = 1;
      @(posedge clk); #1;
      if (push) sent++;
      if (pop)  rcv++;
      c++;
    end
    bus.i_s_valid = 1'b0;
    bus.i_m_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      #4;
      if (bus.o_m_valid) extra++;
      @(posedge clk); #1;
    end
    check_i({name, " beats in"}, sent, nb);
    check_i({name, " beats out"}, rcv, nb);
    check_i({name, " extra beats"}, extra, 0);
    check_i({name, " input stalled"}, int'(saw_full), 1);
    if (toggle) check_i({name, " push+pop when full"}, int'(saw_pushpop), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t post;
    bus.i_m_ready = 1'b1;
    drive_beat(1'b1, '0, '0, '1, '0);
    #2;
    check_i("reset m_valid", int'(bus.o_m_valid), 0);
    check_v("reset m_sum", bus.o_m_sum, '0);
    check_v("reset m_carry", W'(bus.o_m_carry), '0);
    check_i("reset s_ready", int'(bus.o_s_ready), 0);
    @(posedge clk); #1;
    check_i("reset holds m_valid", int'(bus.o_m_valid), 0);
    check_i("reset holds s_ready", int'(bus.o_s_ready), 0);
    bus.i_s_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // lanes packed {lane3, lane2, lane1, lane0}
    vecs.push_back('{{32'h0, 32'h0, 32'h0000FFFF, 32'hFFFFFFFF},
                     {32'h0, 32'h0, 32'h00000001, 32'h00000001}, 4'b1111, '0,
                     {32'h0, 32'h0, 32'h00010000, 32'h00000000}, 4'b0001});
    vecs.push_back('{{4{32'h11111111}}, {4{32'h22222222}}, 4'b1010, '0,
                     {32'h33333333, 32'h11111111, 32'h33333333, 32'h11111111}, 4'b0000});
    vecs.push_back('{{4{32'h80000000}}, {4{32'h80000000}}, 4'b1111, '0,
                     {4{32'h00000000}}, 4'b1111});
    vecs.push_back('{{4{32'hFFFFFFFF}}, {4{32'hFFFFFFFF}}, 4'b0000, '0,
                     {4{32'hFFFFFFFF}}, 4'b0000});
    vecs.push_back('{{32'h7FFFFFFF, 32'h00008000, 32'hFFFFFFFF, 32'h12345678},
                     {32'h00000001, 32'h00008000, 32'hFFFFFFFF, 32'h87654321}, 4'b1111, '0,
                     {32'h80000000, 32'h00010000, 32'hFFFFFFFE, 32'h99999999}, 4'b0010});
    vecs.push_back('{{32'hFFFFFFFE, 32'hDEADBEEF, 32'hFFFF0000, 32'h0000FFFF},
                     {32'h00000003, 32'h00000000, 32'h00010000, 32'hFFFF0000}, 4'b1111, '0,
                     {32'h00000001, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF}, 4'b1010});
`ifdef CHACHA_ADDER_ROTATE_EN
    vecs.push_back('{{4{32'h80000000}}, '0, 4'b1111, ROT_W'(1),
                     {4{32'h00000001}}, 4'b0000});
    vecs.push_back('{{4{32'h01234567}}, '0, 4'b0111, ROT_W'(ROT_16),
                     {32'h01234567, 32'h45670123, 32'h45670123, 32'h45670123}, 4'b0000});
    vecs.push_back('{{4{32'hFFFFFFFF}}, {4{32'h00000002}}, 4'b1111, ROT_W'(ROT_8),
                     {4{32'h00000100}}, 4'b1111});
    vecs.push_back('{{4{32'h00000001}}, '0, 4'b1111, ROT_W'(ROT_7),
                     {4{32'h00000080}}, 4'b0000});
    vecs.push_back('{{4{32'h00000001}}, '0, 4'b1111, ROT_W'(ROT_12),
                     {4{32'h00001000}}, 4'b0000});
`endif

    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

    run_stream(8, 1'b0, "stall");
    run_stream(10, 1'b1, "toggle");

    // Two beats parked in the pipeline, then reset between edges.
    bus.i_m_ready = 1'b0;
    drive_beat(1'b1, {4{32'hAAAA0000}}, {4{32'h00005555}}, '1, '0);
    @(posedge clk); #1;
    drive_beat(1'b1, {4{32'h12340000}}, {4{32'h00005678}}, '1, '0);
    @(posedge clk); #1;
    bus.i_s_valid = 1'b0;
    check_i("pre-reset m_valid", int'(bus.o_m_valid), 1);
    rst = 1'b1;
    #1;
    check_i("async reset m_valid", int'(bus.o_m_valid), 0);
    check_v("async reset m_sum", bus.o_m_sum, '0);
    check_v("async reset m_carry", W'(bus.o_m_carry), '0);
    check_i("async reset s_ready", int'(bus.o_s_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    post = '{{4{32'h0F0F0F0F}}, {4{32'h01010101}}, 4'b1111, '0, {4{32'h10101010}}, 4'b0000};
    apply_vec(post, "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
